sr_stack: RTL and testbench

//   Hardware LIFO stack that services the PUSH/POP custom instructions of sr_cpu.
//   The CPU's decode is the initiator: PUSH stores rs1, POP returns the top of stack into rd.
//   sr_stack is the responder and sits beside sr_cpu's register file inside sm_top.
//   The top of stack is readable combinationally, so the single-cycle CPU writes rd in the POP cycle.
//

---
 rtl/sr_stack.sv | 98 +++++++++
 tb/tb_sr_stack.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/sr_stack.sv
// LIFO stack that serves the PUSH/POP custom instructions of sr_cpu.
// The top of stack and the debug port read combinationally. The error flags stay set until cleared.
module sr_stack #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 32,
   parameter int PTR_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] push_data,
   output logic [WIDTH-1:0] pop_data,
   output logic             empty,
   output logic             full,
   output logic [PTR_W:0]   count,
   output logic             err_ovf,
   output logic             err_udf,
   input  logic             clr_err,
   input  logic [PTR_W-1:0] dbgAddr,
   output logic [WIDTH-1:0] dbgData
);

   localparam logic [PTR_W:0] ONE     = (PTR_W+1)'(1);
   localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W:0]   countQ;
   logic [PTR_W:0]   countM1;
   logic [PTR_W-1:0] topIdx;
   logic [PTR_W-1:0] wrIdx;
   logic             wrEn;
   logic             incCount;
   logic             decCount;
   logic             setOvf;
   logic             setUdf;
   logic             errOvfQ;
   logic             errUdfQ;

   assign empty   = (countQ == '0);
   assign full    = (countQ == DEPTH_C);
   assign countM1 = countQ - ONE;
   assign topIdx  = countM1[PTR_W-1:0];

   // Push with pop on a non-empty stack replaces the top in place. In every
   // other case a push writes at the current count, unless the stack is full.
   always_comb begin
      wrEn     = 1'b0;
      wrIdx    = countQ[PTR_W-1:0];
      incCount = 1'b0;
      decCount = 1'b0;
      setOvf   = 1'b0;
      setUdf   = pop && empty;
      case ({push, pop})
         2'b10: begin
            wrEn     = !full;
            incCount = !full;
            setOvf   = full;
         end
         2'b01: decCount = !empty;
         2'b11: begin
            wrEn     = 1'b1;
            incCount = empty;
            if (!empty) wrIdx = topIdx;
         end
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so that every
   // register samples the values from before the edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         countQ  <= '0;
         errOvfQ <= 1'b0;
         errUdfQ <= 1'b0;
      end else begin
         if (incCount)      countQ <= countQ + ONE;
         else if (decCount) countQ <= countM1;
         // A new error in the same cycle takes priority over clr_err.
         errOvfQ <= setOvf | (errOvfQ & ~clr_err);
         errUdfQ <= setUdf | (errUdfQ & ~clr_err);
      end
   end

   // NOTE: storage is deliberately not reset. The read ports mask stale
   // entries by count, so resetting mem would only cost flops.
   always_ff @(posedge clk) begin
      if (wrEn) mem[wrIdx] <= push_data;
   end

   assign pop_data = empty ? '0 : mem[topIdx];
   assign dbgData  = ({1'b0, dbgAddr} < countQ) ? mem[dbgAddr] : '0;
   assign count    = countQ;
   assign err_ovf  = errOvfQ;
   assign err_udf  = errUdfQ;

endmodule

// File: tb/tb_sr_stack.sv
// Directed bench for sr_stack (DEPTH 16, WIDTH 32) with hand-computed expected values.
// Inputs change 1 ns after a rising edge; outputs are sampled 1 ns after that.
module tb_sr_stack;

   localparam int DEPTH = 16;
   localparam int WIDTH = 32;
   localparam int PTR_W = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             push;
   logic             pop;
   logic [WIDTH-1:0] push_data;
   logic [WIDTH-1:0] pop_data;
   logic             empty;
   logic             full;
   logic [PTR_W:0]   count;
   logic             err_ovf;
   logic             err_udf;
   logic             clr_err;
   logic [PTR_W-1:0] dbgAddr;
   logic [WIDTH-1:0] dbgData;

   int nCompared   = 0;
   int nMismatched = 0;

   sr_stack #(.DEPTH(DEPTH), .WIDTH(WIDTH), .PTR_W(PTR_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .pop       (pop),
      .push_data (push_data),
      .pop_data  (pop_data),
      .empty     (empty),
      .full      (full),
      .count     (count),
      .err_ovf   (err_ovf),
      .err_udf   (err_udf),
      .clr_err   (clr_err),
      .dbgAddr   (dbgAddr),
      .dbgData   (dbgData)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nCompared++;
      if (obs !== exp) begin
         nMismatched++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic ps, input logic pp, input logic [31:0] d,
                        input logic clr = 1'b0);
      push      = ps;
      pop       = pp;
      push_data = d;
      clr_err   = clr;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      drive(1'b0, 1'b0, 32'h0);
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 32'h0);
      tick();
      rst_n = 1'b1;
   endtask

   task automatic checkState(input string tag, input int expCount, input logic expOvf,
                             input logic expUdf, input logic [31:0] expTop);
      check({tag, ".count"}, 32'(count), 32'(expCount));
      check({tag, ".empty"}, 32'(empty), 32'(expCount == 0));
      check({tag, ".full"},  32'(full),  32'(expCount == DEPTH));
      check({tag, ".ovf"},   32'(err_ovf), 32'(expOvf));
      check({tag, ".udf"},   32'(err_udf), 32'(expUdf));
      check({tag, ".top"},   pop_data, expTop);
   endtask

   initial begin
      rst_n   = 1'b0;
      dbgAddr = '0;
      drive(1'b0, 1'b0, 32'h0);
      @(posedge clk);
      #1;

      // 1: reset, then idle
      doReset();
      tick();
      checkState("reset", 0, 1'b0, 1'b0, 32'h0);

      // 2: three pushes, three pops, read out in LIFO order
      drive(1'b1, 1'b0, 32'h11); tick();
      drive(1'b1, 1'b0, 32'h22); tick();
      drive(1'b1, 1'b0, 32'h33); tick();
      checkState("push3", 3, 1'b0, 1'b0, 32'h33);
      drive(1'b0, 1'b1, 32'h0); check("pop1.data", pop_data, 32'h33); tick();
      drive(1'b0, 1'b1, 32'h0); check("pop2.data", pop_data, 32'h22); tick();
      check("pop2.count", 32'(count), 32'd1);
      drive(1'b0, 1'b1, 32'h0); check("pop3.data", pop_data, 32'h11); tick();
      checkState("pop3", 0, 1'b0, 1'b0, 32'h0);

      // 3: fill to DEPTH, then an overflowing push is dropped
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b1, 1'b0, 32'(i));
         tick();
      end
      checkState("fill", 16, 1'b0, 1'b0, 32'd15);
      drive(1'b1, 1'b0, 32'hDEAD); tick();
      checkState("ovf", 16, 1'b1, 1'b0, 32'd15);
      dbgAddr = 4'd15; #1; check("dbg15", dbgData, 32'd15);
      dbgAddr = 4'd0;  #1; check("dbg0", dbgData, 32'd0);
      dbgAddr = 4'd7;  #1; check("dbg7", dbgData, 32'd7);

      // 5b: replace the top while full; sets no error and keeps count at 16
      drive(1'b0, 1'b0, 32'h0, 1'b1); tick();
      check("clrOvf", 32'(err_ovf), 32'd0);
      drive(1'b1, 1'b1, 32'hBEEF); check("fullRep.data", pop_data, 32'd15); tick();
      checkState("fullRep", 16, 1'b0, 1'b0, 32'hBEEF);
      dbgAddr = 4'd14; #1; check("fullRep.dbg14", dbgData, 32'd14);

      // 4: underflow, then clearing, then clear and underflow in the same cycle
      doReset();
      drive(1'b0, 1'b1, 32'h0); check("udf.data", pop_data, 32'h0); tick();
      checkState("udf", 0, 1'b0, 1'b1, 32'h0);
      drive(1'b0, 1'b0, 32'h0); tick();
      check("udfSticky", 32'(err_udf), 32'd1);
      drive(1'b0, 1'b0, 32'h0, 1'b1); tick();
      check("udfClr", 32'(err_udf), 32'd0);
      drive(1'b0, 1'b1, 32'h0, 1'b1); tick();
      checkState("udfClrPop", 0, 1'b0, 1'b1, 32'h0);

      // 5: replace the top of a one-entry stack
      drive(1'b0, 1'b0, 32'h0, 1'b1); tick();
      drive(1'b1, 1'b0, 32'hA); tick();
      drive(1'b1, 1'b1, 32'hB); check("rep.data", pop_data, 32'hA); tick();
      checkState("rep", 1, 1'b0, 1'b0, 32'hB);
      dbgAddr = 4'd1; #1; check("dbgAboveCount", dbgData, 32'h0);

      // push and pop together on an empty stack: underflow, and the push still lands
      doReset();
      drive(1'b1, 1'b1, 32'h5A5A); check("emptyBoth.data", pop_data, 32'h0); tick();
      checkState("emptyBoth", 1, 1'b0, 1'b1, 32'h5A5A);

      // 6: a reset in the middle of a sequence overrides a simultaneous push
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 1'b0, 32'h100 + 32'(i));
         tick();
      end
      check("pre6.count", 32'(count), 32'd6);
      rst_n = 1'b0;
      drive(1'b1, 1'b0, 32'hCAFE);
      tick();
      rst_n = 1'b1;
      checkState("rstMid", 0, 1'b0, 1'b0, 32'h0);
      dbgAddr = 4'd0; #1; check("rstMid.dbg0", dbgData, 32'h0);
      drive(1'b1, 1'b0, 32'h77); tick();
      checkState("postRst", 1, 1'b0, 1'b0, 32'h77);
      dbgAddr = 4'd0; #1; check("postRst.dbg0", dbgData, 32'h77);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
